// File: rtl/cva6_ptw_sv32_lite.sv
// cva6_ptw_sv32_lite
// Minimal Sv32 page-table walker feeding the cva6_tlb_sv32 update port.
// Takes a TLB miss and walks the two-level Sv32 table through a req/gnt/rvalid
// read port. It then emits either a one-cycle update word or a page-fault pulse.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             abort any walk in progress (no update, no fault)
//   satp_ppn_i          root page-table PPN, sampled on miss acceptance
//   miss_valid_i/_ready_o, miss_vaddr_i, miss_asid_i   miss request handshake
//   mem_req_o, mem_addr_o, mem_gnt_i                   PTE read request
//   mem_rvalid_i, mem_rdata_i                          PTE read response
//   update_o            {valid, is_4M, vpn[19:0], asid[8:0], pte[31:0]}
//   walking_o           high whenever the walker is not idle
//   fault_o             one-cycle page-fault pulse
//   fault_vaddr_o       vaddr of the most recent fault
module cva6_ptw_sv32_lite #(
    parameter int unsigned ASID_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [21:0]           satp_ppn_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [31:0]           miss_vaddr_i,
    input  logic [ASID_WIDTH-1:0] miss_asid_i,
    output logic                  mem_req_o,
    output logic [33:0]           mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [62:0]           update_o,
    output logic                  walking_o,
    output logic                  fault_o,
    output logic [31:0]           fault_vaddr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_REQ,
        S_L1_WAIT,
        S_L0_REQ,
        S_L0_WAIT,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [31:0]           vaddr_q;
    logic [ASID_WIDTH-1:0] asid_q;
    logic [21:0]           root_ppn_q;
    logic [21:0]           l0_ppn_q;

    logic        upd_valid_q;
    logic [61:0] upd_payload_q;

    logic accept;
    logic l1_done, l0_done;
    logic pte_invalid, pte_leaf, pte_misaligned;
    logic take_update, take_fault, take_4m, take_next;

    // PTE decode on the raw read data; only meaningful while a WAIT state sees rvalid
    always_comb begin
        pte_invalid    = !mem_rdata_i[0] || (!mem_rdata_i[1] && mem_rdata_i[2]);
        pte_leaf       = mem_rdata_i[1] || mem_rdata_i[3];
        pte_misaligned = (mem_rdata_i[19:10] != 10'd0);
    end

    // A response that coincides with flush_i is discarded, so it never decides
    assign l1_done = (state_q == S_L1_WAIT) && mem_rvalid_i && !flush_i;
    assign l0_done = (state_q == S_L0_WAIT) && mem_rvalid_i && !flush_i;
    assign accept  = miss_valid_i && miss_ready_o;

    always_comb begin
        take_update = 1'b0;
        take_fault  = 1'b0;
        take_4m     = 1'b0;
        take_next   = 1'b0;
        if (l1_done) begin
            if (pte_invalid) begin
                take_fault = 1'b1;
            end else if (pte_leaf) begin
                if (pte_misaligned) begin
                    take_fault = 1'b1;
                end else begin
                    take_update = 1'b1;
                    take_4m     = 1'b1;
                end
            end else begin
                take_next = 1'b1;
            end
        end
        if (l0_done) begin
            if (pte_invalid || !pte_leaf) begin
                take_fault = 1'b1;
            end else begin
                take_update = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_L1_REQ;
            end
            S_L1_REQ: begin
                if (flush_i)        state_d = S_IDLE;
                else if (mem_gnt_i) state_d = S_L1_WAIT;
            end
            S_L1_WAIT: begin
                // Flush with the response already here has nothing left to drain
                if (flush_i)           state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
                else if (mem_rvalid_i) state_d = take_next ? S_L0_REQ : S_IDLE;
            end
            S_L0_REQ: begin
                if (flush_i)        state_d = S_IDLE;
                else if (mem_gnt_i) state_d = S_L0_WAIT;
            end
            S_L0_WAIT: begin
                if (flush_i)           state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
                else if (mem_rvalid_i) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rvalid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        miss_ready_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        walking_o    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                miss_ready_o = !flush_i;
            end
            S_L1_REQ: begin
                mem_req_o  = !flush_i;
                mem_addr_o = {root_ppn_q, vaddr_q[31:22], 2'b00};
            end
            S_L0_REQ: begin
                mem_req_o  = !flush_i;
                mem_addr_o = {l0_ppn_q, vaddr_q[21:12], 2'b00};
            end
            default: ;
        endcase
    end

    // Walk context
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vaddr_q    <= '0;
            asid_q     <= '0;
            root_ppn_q <= '0;
            l0_ppn_q   <= '0;
        end else begin
            if (accept) begin
                vaddr_q    <= miss_vaddr_i;
                asid_q     <= miss_asid_i;
                root_ppn_q <= satp_ppn_i;
            end
            if (take_next) begin
                l0_ppn_q <= mem_rdata_i[31:10];
            end
        end
    end

    // Registered outcomes: valid/fault pulse for one cycle, payloads hold
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            upd_valid_q   <= 1'b0;
            upd_payload_q <= '0;
            fault_o       <= 1'b0;
            fault_vaddr_o <= '0;
        end else begin
            upd_valid_q <= take_update;
            fault_o     <= take_fault;
            if (take_update) begin
                upd_payload_q <= {take_4m, vaddr_q[31:12], 9'(asid_q), mem_rdata_i};
            end
            if (take_fault) begin
                fault_vaddr_o <= vaddr_q;
            end
        end
    end

    assign update_o = {upd_valid_q, upd_payload_q};

endmodule

// File: tb/tb_cva6_ptw_sv32_lite.sv
module tb_cva6_ptw_sv32_lite;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [21:0] satp_ppn;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_vaddr;
    logic [0:0]  miss_asid;
    logic        mem_req;
    logic [33:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [62:0] update;
    logic        walking;
    logic        fault;
    logic [31:0] fault_vaddr;

    int checks = 0;
    int errors = 0;

    cva6_ptw_sv32_lite #(.ASID_WIDTH(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .satp_ppn_i   (satp_ppn),
        .miss_valid_i (miss_valid),
        .miss_ready_o (miss_ready),
        .miss_vaddr_i (miss_vaddr),
        .miss_asid_i  (miss_asid),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .update_o     (update),
        .walking_o    (walking),
        .fault_o      (fault),
        .fault_vaddr_o(fault_vaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a miss for one accepting edge
    task automatic accept_miss(input logic [31:0] va, input logic asid);
        satp_ppn   = 22'h00001;
        miss_vaddr = va;
        miss_asid  = asid;
        miss_valid = 1'b1;
        #1;
        check("accept_ready", {63'd0, miss_ready}, 64'd1);
        tick();
        miss_valid = 1'b0;
    endtask

    // One read with grant in the request cycle and data the next cycle
    task automatic serve(input logic [31:0] data);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        satp_ppn   = '0;
        miss_valid = 1'b0;
        miss_vaddr = '0;
        miss_asid  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        tick();

        // Reset state
        check("rst_ready",   {63'd0, miss_ready}, 64'd1);
        check("rst_req",     {63'd0, mem_req}, 64'd0);
        check("rst_update",  {1'b0, update}, 64'd0);
        check("rst_walking", {63'd0, walking}, 64'd0);
        check("rst_fault",   {63'd0, fault}, 64'd0);
        check("rst_fvaddr",  {32'd0, fault_vaddr}, 64'd0);
        rst = 1'b0;
        tick();

        // 4K walk
        accept_miss(32'h00403000, 1'b1);
        check("4k_l1_req",  {63'd0, mem_req}, 64'd1);
        check("4k_l1_addr", {30'd0, mem_addr}, 64'h1004);
        check("4k_walking", {63'd0, walking}, 64'd1);
        check("4k_busy",    {63'd0, miss_ready}, 64'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check("4k_wait_noreq", {63'd0, mem_req}, 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00000801;
        tick();
        mem_rvalid = 1'b0;
        check("4k_l0_req",  {63'd0, mem_req}, 64'd1);
        check("4k_l0_addr", {30'd0, mem_addr}, 64'h200C);
        check("4k_no_early_upd", {63'd0, update[62]}, 64'd0);
        serve(32'h000040CF);
        check("4k_update", {1'b0, update}, {1'b0, 1'b1, 1'b0, 20'h00403, 9'h001, 32'h000040CF});
        check("4k_nofault", {63'd0, fault}, 64'd0);
        check("4k_ready",   {63'd0, miss_ready}, 64'd1);
        tick();
        check("4k_pulse_end", {1'b0, update}, {1'b0, 1'b0, 1'b0, 20'h00403, 9'h001, 32'h000040CF});

        // 4M superpage
        accept_miss(32'h00403000, 1'b0);
        check("4m_l1_addr", {30'd0, mem_addr}, 64'h1004);
        serve(32'h000000CF);
        check("4m_update", {1'b0, update}, {1'b0, 1'b1, 1'b1, 20'h00403, 9'h000, 32'h000000CF});
        check("4m_single_read", {63'd0, mem_req}, 64'd0);
        check("4m_idle", {63'd0, walking}, 64'd0);
        tick();

        // Misaligned superpage
        accept_miss(32'h00403000, 1'b1);
        serve(32'h000004CF);
        check("mis_fault",  {63'd0, fault}, 64'd1);
        check("mis_fvaddr", {32'd0, fault_vaddr}, 64'h00403000);
        check("mis_noupd",  {63'd0, update[62]}, 64'd0);
        check("mis_payload_held", {2'd0, update[61:0]}, {2'd0, 1'b1, 20'h00403, 9'h000, 32'h000000CF});
        tick();
        check("mis_pulse_end", {63'd0, fault}, 64'd0);

        // Invalid L1 PTE
        accept_miss(32'h12345000, 1'b0);
        check("inv_l1_addr", {30'd0, mem_addr}, 64'h1120);
        serve(32'h00000800);
        check("inv_fault",  {63'd0, fault}, 64'd1);
        check("inv_fvaddr", {32'd0, fault_vaddr}, 64'h12345000);
        check("inv_noupd",  {63'd0, update[62]}, 64'd0);
        check("inv_ready",  {63'd0, miss_ready}, 64'd1);
        tick();
        check("inv_fvaddr_hold", {32'd0, fault_vaddr}, 64'h12345000);

        // Flush during L0_WAIT, then drain
        accept_miss(32'h00403000, 1'b1);
        serve(32'h00000801);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_drain_walk",  {63'd0, walking}, 64'd1);
        check("fl_drain_busy",  {63'd0, miss_ready}, 64'd0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h000040CF;
        tick();
        mem_rvalid = 1'b0;
        #1;
        check("fl_noupd",   {63'd0, update[62]}, 64'd0);
        check("fl_nofault", {63'd0, fault}, 64'd0);
        check("fl_ready",   {63'd0, miss_ready}, 64'd1);
        tick();

        // Stalled grant, then flush while stalled
        accept_miss(32'h00403000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_req",  {63'd0, mem_req}, 64'd1);
            check("stall_addr", {30'd0, mem_addr}, 64'h1004);
            tick();
        end
        flush = 1'b1;
        #1;
        check("stall_flush_req", {63'd0, mem_req}, 64'd0);
        tick();
        check("stall_flush_idle", {63'd0, walking}, 64'd0);
        // flush in IDLE blocks acceptance
        miss_valid = 1'b1;
        #1;
        check("flush_blocks_ready", {63'd0, miss_ready}, 64'd0);
        tick();
        miss_valid = 1'b0;
        flush      = 1'b0;
        check("flush_blocks_accept", {63'd0, walking}, 64'd0);
        tick();

        // Reset in L1_WAIT
        accept_miss(32'h00403000, 1'b1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        #1;
        check("mrst_idle",   {63'd0, walking}, 64'd0);
        check("mrst_ready",  {63'd0, miss_ready}, 64'd1);
        check("mrst_update", {1'b0, update}, 64'd0);
        check("mrst_fvaddr", {32'd0, fault_vaddr}, 64'd0);
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h000000CF;
        tick();
        mem_rvalid = 1'b0;
        #1;
        check("mrst_stray_noupd", {63'd0, update[62]}, 64'd0);
        check("mrst_stray_nofault", {63'd0, fault}, 64'd0);
        check("mrst_stray_idle", {63'd0, walking}, 64'd0);

        // Fresh walk after reset
        accept_miss(32'h00403000, 1'b1);
        check("post_l1_addr", {30'd0, mem_addr}, 64'h1004);
        serve(32'h00000801);
        check("post_l0_addr", {30'd0, mem_addr}, 64'h200C);
        serve(32'h000040CF);
        check("post_update", {1'b0, update}, {1'b0, 1'b1, 1'b0, 20'h00403, 9'h001, 32'h000040CF});
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
